// File: rtl/hpdcache_pkg.sv
// Shared scalar types for the hpdcache upsizing buffer.
package hpdcache_pkg;
    typedef int unsigned hpdcache_uint;

    // Index width for a range of n values, never narrower than one bit.
    function automatic int hpdcache_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/hpdcache_data_upsize_ext_if.sv
// Write/read/flush bundle of the upsizing buffer.
// Optional HPDCACHE_DATA_UPSIZE_WMASK_EN adds the rmask_o head-entry word mask.
interface hpdcache_data_upsize_ext_if #(
    parameter int WR_WIDTH = 64,
    parameter int RD_WIDTH = 512
) ();
    localparam int WR_WORDS = RD_WIDTH / WR_WIDTH;
    localparam int CNT_W    = $clog2(WR_WORDS + 1);

    logic                flush_i;
    logic                w_i;
    logic                wlast_i;
    logic                wok_o;
    logic [WR_WIDTH-1:0] wdata_i;
    logic                r_i;
    logic                rok_o;
    logic [RD_WIDTH-1:0] rdata_o;
    logic [CNT_W-1:0]    rcnt_o;
`ifdef HPDCACHE_DATA_UPSIZE_WMASK_EN
    logic [WR_WORDS-1:0] rmask_o;
`endif

    modport master (
        output flush_i, w_i, wlast_i, wdata_i, r_i,
`ifdef HPDCACHE_DATA_UPSIZE_WMASK_EN
        input  rmask_o,
`endif
        input  wok_o, rok_o, rdata_o, rcnt_o
    );

    modport slave (
        input  flush_i, w_i, wlast_i, wdata_i, r_i,
`ifdef HPDCACHE_DATA_UPSIZE_WMASK_EN
        output rmask_o,
`endif
        output wok_o, rok_o, rdata_o, rcnt_o
    );
endinterface

// File: rtl/hpdcache_wrap_counter.sv
// Modulo-MAX counter (0..MAX-1) with synchronous clear taking priority over increment.
module hpdcache_wrap_counter
    import hpdcache_pkg::*;
#(
    parameter int MAX = 2,
    localparam int W  = hpdcache_idx_w(MAX)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)  cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= (hpdcache_uint'(cnt) == hpdcache_uint'(MAX - 1)) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/hpdcache_data_upsize_ext.sv
// Narrow-write / wide-read FIFO: WR_WIDTH words gather into RD_WIDTH entries.
// Define HPDCACHE_DATA_UPSIZE_WMASK_EN to export the head-entry word mask on rmask_o.
module hpdcache_data_upsize_ext
    import hpdcache_pkg::*;
#(
    parameter int WR_WIDTH = 64,
    parameter int RD_WIDTH = 512,
    parameter int DEPTH    = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    hpdcache_data_upsize_ext_if.slave   bus
);
    localparam int WR_WORDS = RD_WIDTH / WR_WIDTH;
    localparam int PTR_W    = hpdcache_idx_w(DEPTH);
    localparam int USED_W   = $clog2(DEPTH + 1);
    localparam int WCNT_W   = hpdcache_idx_w(WR_WORDS);
    localparam int CNT_W    = $clog2(WR_WORDS + 1);

    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [USED_W-1:0] used_t;
    typedef logic [WCNT_W-1:0] wcnt_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    logic [DEPTH-1:0][WR_WORDS-1:0][WR_WIDTH-1:0] data_q;
    logic [DEPTH-1:0][WR_WORDS-1:0]               mask_q;
    cnt_t [DEPTH-1:0]                             cnt_q;
    used_t                                        used_q;
    wcnt_t                                        wcnt_q;
    ptr_t                                         wrptr, rdptr;

    logic wr_acc, wr_close, rd_pop, last_word;
    logic [WR_WORDS-1:0]               head_mask;
    logic [WR_WORDS-1:0][WR_WIDTH-1:0] head_data;

    assign bus.wok_o = hpdcache_uint'(used_q) < hpdcache_uint'(DEPTH);
    assign bus.rok_o = hpdcache_uint'(used_q) != 0;

    assign last_word = hpdcache_uint'(wcnt_q) == hpdcache_uint'(WR_WORDS - 1);
    assign wr_acc    = bus.w_i & bus.wok_o & ~bus.flush_i;
    assign wr_close  = wr_acc & (last_word | bus.wlast_i);
    assign rd_pop    = bus.r_i & bus.rok_o & ~bus.flush_i;

    hpdcache_wrap_counter #(.MAX(DEPTH)) u_wrptr (
        .clk_i (clk_i), .rst_ni(rst_ni), .clr(bus.flush_i), .inc(wr_close), .cnt(wrptr)
    );
    hpdcache_wrap_counter #(.MAX(DEPTH)) u_rdptr (
        .clk_i (clk_i), .rst_ni(rst_ni), .clr(bus.flush_i), .inc(rd_pop), .cnt(rdptr)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            used_q <= '0;
            wcnt_q <= '0;
            mask_q <= '0;
        end else if (bus.flush_i) begin
            used_q <= '0;
            wcnt_q <= '0;
            mask_q <= '0;
        end else begin
            if (wr_acc) begin
                // First word of an entry wipes the slot's old mask so leftovers read as zero.
                if (wcnt_q == '0) mask_q[wrptr] <= WR_WORDS'(1);
                else              mask_q[wrptr][wcnt_q] <= 1'b1;
                wcnt_q <= wr_close ? '0 : wcnt_q + 1'b1;
            end
            case ({wr_close, rd_pop})
                2'b10:   used_q <= used_q + 1'b1;
                2'b01:   used_q <= used_q - 1'b1;
                default: used_q <= used_q;
            endcase
        end
    end

    // Payload and word counts need no reset: the masks and used_q gate them.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            data_q[wrptr][wcnt_q] <= bus.wdata_i;
            if (wr_close) cnt_q[wrptr] <= cnt_t'(wcnt_q) + 1'b1;
        end
    end

    assign head_mask = bus.rok_o ? mask_q[rdptr] : '0;

    for (genvar k = 0; k < WR_WORDS; k++) begin : g_word
        assign head_data[k] = head_mask[k] ? data_q[rdptr][k] : '0;
    end

    assign bus.rdata_o = head_data;
    assign bus.rcnt_o  = bus.rok_o ? cnt_q[rdptr] : '0;
`ifdef HPDCACHE_DATA_UPSIZE_WMASK_EN
    assign bus.rmask_o = head_mask;
`endif
endmodule

// File: tb/tb_hpdcache_data_upsize_ext.sv
// Directed bench: 64->256 upsizer, DEPTH 2 (instance a) and DEPTH 3 (instance b).
module tb_hpdcache_data_upsize_ext;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hpdcache_data_upsize_ext_if #(.WR_WIDTH(64), .RD_WIDTH(256)) ia ();
    hpdcache_data_upsize_ext_if #(.WR_WIDTH(64), .RD_WIDTH(256)) ib ();

    hpdcache_data_upsize_ext #(.WR_WIDTH(64), .RD_WIDTH(256), .DEPTH(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(ia)
    );
    hpdcache_data_upsize_ext #(.WR_WIDTH(64), .RD_WIDTH(256), .DEPTH(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(ib)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [63:0] d, input logic last);
        ia.w_i = 1'b1; ia.wdata_i = d; ia.wlast_i = last;
        tick();
        ia.w_i = 1'b0; ia.wlast_i = 1'b0;
    endtask

    task automatic pop_a();
        ia.r_i = 1'b1;
        tick();
        ia.r_i = 1'b0;
    endtask

    task automatic pop_b();
        ib.r_i = 1'b1;
        tick();
        ib.r_i = 1'b0;
    endtask

    // Entry i of the wrap stream holds (i%4)+1 words, word k = i*256+k+1.
    function automatic logic [255:0] exp_entry(input int i);
        logic [255:0] v = '0;
        for (int k = 0; k < (i % 4) + 1; k++) v[k*64 +: 64] = 64'(i * 256 + k + 1);
        return v;
    endfunction

    task automatic write_entry_b(input int i);
        int n = (i % 4) + 1;
        for (int k = 0; k < n; k++) begin
            ib.w_i = 1'b1; ib.wdata_i = 64'(i * 256 + k + 1); ib.wlast_i = (k == n - 1);
            tick();
        end
        ib.w_i = 1'b0; ib.wlast_i = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (ia.wok_o !== 1'b1) begin errors++; $display("FAIL reset_wok got=%b exp=1", ia.wok_o); end
        checks++; if (ia.rok_o !== 1'b0) begin errors++; $display("FAIL reset_rok got=%b exp=0", ia.rok_o); end
        checks++; if (ia.rdata_o !== 256'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", ia.rdata_o); end
        checks++; if (ia.rcnt_o !== 3'd0) begin errors++; $display("FAIL reset_rcnt got=%0d exp=0", ia.rcnt_o); end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_fill();
        wr_a(64'h1, 1'b0); wr_a(64'h2, 1'b0); wr_a(64'h3, 1'b0);
        checks++; if (ia.rok_o !== 1'b0) begin errors++; $display("FAIL partial_hidden rok got=%b exp=0", ia.rok_o); end
        wr_a(64'h4, 1'b0);
        checks++; if (ia.rok_o !== 1'b1) begin errors++; $display("FAIL fill_rok got=%b exp=1", ia.rok_o); end
        checks++; if (ia.rdata_o !== {64'h4, 64'h3, 64'h2, 64'h1}) begin errors++; $display("FAIL fill_rdata got=%h", ia.rdata_o); end
        checks++; if (ia.rcnt_o !== 3'd4) begin errors++; $display("FAIL fill_rcnt got=%0d exp=4", ia.rcnt_o); end
        pop_a();
        checks++; if (ia.rok_o !== 1'b0 || ia.rdata_o !== 256'h0) begin errors++; $display("FAIL empty_after_pop rok=%b rdata=%h exp 0/0", ia.rok_o, ia.rdata_o); end
    endtask

    task automatic test_early_close();
        // Second pass lands in slot 0, whose words 2..3 still hold 3 and 4.
        for (int pass = 0; pass < 2; pass++) begin
            wr_a(64'hA, 1'b0); wr_a(64'hB, 1'b1);
            checks++; if (ia.rdata_o !== {128'h0, 64'hB, 64'hA}) begin errors++; $display("FAIL early_rdata pass=%0d got=%h", pass, ia.rdata_o); end
            checks++; if (ia.rcnt_o !== 3'd2) begin errors++; $display("FAIL early_rcnt pass=%0d got=%0d exp=2", pass, ia.rcnt_o); end
`ifdef HPDCACHE_DATA_UPSIZE_WMASK_EN
            checks++; if (ia.rmask_o !== 4'b0011) begin errors++; $display("FAIL early_rmask got=%b exp=0011", ia.rmask_o); end
`endif
            pop_a();
        end
    endtask

    task automatic test_full();
        wr_a(64'h11, 1'b1); wr_a(64'h22, 1'b1);
        checks++; if (ia.wok_o !== 1'b0) begin errors++; $display("FAIL full_wok got=%b exp=0", ia.wok_o); end
        wr_a(64'h33, 1'b1);
        checks++; if (ia.rdata_o !== 256'h11) begin errors++; $display("FAIL full_head got=%h exp=11", ia.rdata_o); end
        pop_a();
        checks++; if (ia.wok_o !== 1'b1) begin errors++; $display("FAIL wok_after_pop got=%b exp=1", ia.wok_o); end
        checks++; if (ia.rdata_o !== 256'h22) begin errors++; $display("FAIL full_second got=%h exp=22", ia.rdata_o); end
        pop_a();
        checks++; if (ia.rok_o !== 1'b0) begin errors++; $display("FAIL extra_write_dropped rok got=%b exp=0", ia.rok_o); end
    endtask

    task automatic test_back_to_back();
        wr_a(64'h55, 1'b1);
        ia.r_i = 1'b1; ia.w_i = 1'b1; ia.wdata_i = 64'h66; ia.wlast_i = 1'b1;
        tick();
        ia.r_i = 1'b0; ia.w_i = 1'b0; ia.wlast_i = 1'b0;
        checks++; if (ia.rok_o !== 1'b1 || ia.rdata_o !== 256'h66) begin errors++; $display("FAIL concur_head rok=%b rdata=%h exp 1/66", ia.rok_o, ia.rdata_o); end
        checks++; if (ia.wok_o !== 1'b1) begin errors++; $display("FAIL concur_wok got=%b exp=1", ia.wok_o); end
        pop_a();
        checks++; if (ia.rok_o !== 1'b0) begin errors++; $display("FAIL concur_used got rok=%b exp=0", ia.rok_o); end
    endtask

    task automatic test_flush();
        wr_a(64'h77, 1'b1); wr_a(64'h88, 1'b0);
        ia.flush_i = 1'b1; ia.r_i = 1'b1; ia.w_i = 1'b1; ia.wdata_i = 64'h99; ia.wlast_i = 1'b1;
        tick();
        ia.flush_i = 1'b0; ia.r_i = 1'b0; ia.w_i = 1'b0; ia.wlast_i = 1'b0;
        checks++; if (ia.rok_o !== 1'b0 || ia.wok_o !== 1'b1) begin errors++; $display("FAIL flush_state rok=%b wok=%b exp 0/1", ia.rok_o, ia.wok_o); end
        wr_a(64'hAA, 1'b1);
        checks++; if (ia.rdata_o !== 256'hAA || ia.rcnt_o !== 3'd1) begin errors++; $display("FAIL flush_word0 rdata=%h rcnt=%0d exp AA/1", ia.rdata_o, ia.rcnt_o); end
        pop_a();
    endtask

    task automatic test_reset_midfill();
        wr_a(64'hC, 1'b1); wr_a(64'hD, 1'b0);
        checks++; if (ia.rok_o !== 1'b1) begin errors++; $display("FAIL pre_reset_rok got=%b exp=1", ia.rok_o); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (ia.rok_o !== 1'b0 || ia.wok_o !== 1'b1) begin errors++; $display("FAIL async_reset rok=%b wok=%b exp 0/1", ia.rok_o, ia.wok_o); end
        checks++; if (ia.rdata_o !== 256'h0 || ia.rcnt_o !== 3'd0) begin errors++; $display("FAIL async_reset_data rdata=%h rcnt=%0d", ia.rdata_o, ia.rcnt_o); end
        #1 rst_n = 1'b1;
        tick();
        wr_a(64'hE, 1'b1);
        checks++; if (ia.rdata_o !== 256'hE || ia.rcnt_o !== 3'd1) begin errors++; $display("FAIL reset_word0 rdata=%h rcnt=%0d exp E/1", ia.rdata_o, ia.rcnt_o); end
        pop_a();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) write_entry_b(i);
        checks++; if (ib.wok_o !== 1'b0) begin errors++; $display("FAIL wrap_full wok got=%b exp=0", ib.wok_o); end
        for (int i = 3; i < 10; i++) begin
            checks++; if (ib.rdata_o !== exp_entry(i - 3)) begin errors++; $display("FAIL wrap_data entry=%0d got=%h exp=%h", i - 3, ib.rdata_o, exp_entry(i - 3)); end
            checks++; if (ib.rcnt_o !== 3'((i - 3) % 4 + 1)) begin errors++; $display("FAIL wrap_rcnt entry=%0d got=%0d exp=%0d", i - 3, ib.rcnt_o, (i - 3) % 4 + 1); end
            pop_b();
            if (i < 7) write_entry_b(i);
        end
        checks++; if (ib.rok_o !== 1'b0) begin errors++; $display("FAIL wrap_drained rok got=%b exp=0", ib.rok_o); end
    endtask

    initial begin
        ia.flush_i = 1'b0; ia.w_i = 1'b0; ia.wlast_i = 1'b0; ia.wdata_i = '0; ia.r_i = 1'b0;
        ib.flush_i = 1'b0; ib.w_i = 1'b0; ib.wlast_i = 1'b0; ib.wdata_i = '0; ib.r_i = 1'b0;
        test_reset();
        test_full_fill();
        test_early_close();
        test_full();
        test_back_to_back();
        test_flush();
        test_reset_midfill();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hpdcache_data_upsize_ext.md
HPDCACHE_DATA_UPSIZE_EXT -- requirements
Module: hpdcache_data_upsize_ext

Interface
REQ-001 SHALL have parameter WR_WIDTH, default 64, write-word width in bits.
REQ-002 SHALL have parameter RD_WIDTH, default 512, read-entry width in bits; WR_WORDS = RD_WIDTH/WR_WIDTH.
REQ-003 SHALL have parameter DEPTH, default 2, number of entries; any value >= 1, not restricted to powers of two.
REQ-004 SHALL have port clk_i  input  1  clock; one clock, all state on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port flush_i  input  1  discard all entries, including a partial one.
REQ-007 SHALL have port w_i  input  1  write request.
REQ-008 SHALL have port wlast_i  input  1  current word closes the entry.
REQ-009 SHALL have port wok_o  output  1  write accepted when high.
REQ-010 SHALL have port wdata_i  input  WR_WIDTH  write word.
REQ-011 SHALL have port r_i  input  1  read/pop request.
REQ-012 SHALL have port rok_o  output  1  a closed entry is available.
REQ-013 SHALL have port rdata_o  output  RD_WIDTH  head entry; word k at bits [k*WR_WIDTH +: WR_WIDTH].
REQ-014 SHALL have port rcnt_o  output  clog2(WR_WORDS+1)  number of valid words in head entry.

Function
REQ-015 SHALL accept a write when w_i && wok_o; wok_o = (used < DEPTH), independent of r_i.
REQ-016 SHALL store the accepted word at word index wcnt of entry wrptr, then increment wcnt.
REQ-017 SHALL close the entry when wcnt == WR_WORDS-1 or wlast_i: used += 1, wrptr advances, wcnt returns to 0.
REQ-018 SHALL pop the head entry when r_i && rok_o; rok_o = (used != 0); rdptr advances.
REQ-019 SHALL wrap wrptr and rdptr from DEPTH-1 to 0.
REQ-020 SHALL, on a same-cycle close and pop, leave used unchanged.
REQ-021 SHALL present unwritten words of a closed entry as zero on rdata_o, never stale data.
REQ-022 SHALL have zero latency from pop to the next entry appearing on rdata_o/rcnt_o; a closed entry is visible the cycle after its closing write.
REQ-023 SHALL give flush_i priority over writes and pops in the same cycle: used, wcnt, wrptr and rdptr go to 0; the write is dropped.
REQ-024 SHALL never show a partial (unclosed) entry on rok_o/rdata_o.
REQ-025 SHALL produce rdata_o = 0, rcnt_o = 0 when empty.

Reset
REQ-026 SHALL, on rst_ni low, clear pointers, used, wcnt and valid-word masks immediately (asynchronously).
REQ-027 SHALL hold outputs during reset at wok_o = 1, rok_o = 0, rdata_o = 0, rcnt_o = 0.
REQ-028 SHALL need no data-array reset; zeroing of data is done by the masks.

Configuration
REQ-029 SHALL, with HPDCACHE_DATA_UPSIZE_WMASK_EN defined, add output rmask_o (WR_WORDS bits; bit k = word k of head entry written; 0 when empty).
REQ-030 SHALL, without HPDCACHE_DATA_UPSIZE_WMASK_EN, have no rmask_o port; all other behaviour is identical.

Structure
REQ-031 SHALL use hpdcache_uint from hpdcache_pkg for comparisons; the pointer and count typedefs are local to the module.
REQ-032 SHALL use one sub-module, hpdcache_wrap_counter (parameter MAX, with inc and clr inputs), for wrptr and rdptr.

Verification
REQ-033 SHALL cover full-entry fill: WR 64/RD 256, DEPTH 2, 4 writes 0x1..0x4 -> rok_o = 1, rdata_o = 0x4_3_2_1 (64-bit words), rcnt_o = 4.
REQ-034 SHALL cover early close: 2 writes 0xA, 0xB with wlast_i on the second -> rdata_o upper 128 bits 0, rcnt_o = 2, rmask_o = 4'b0011.
REQ-035 SHALL cover full: DEPTH 2 filled -> wok_o = 0, extra write ignored; one pop -> wok_o = 1 next cycle.
REQ-036 SHALL cover wrap: DEPTH 3, 7 entries streamed with interleaved pops -> in-order data, no loss.
REQ-037 SHALL cover concurrency: closing write and pop in the same cycle at used = 1 -> used stays 1, new entry at head.
REQ-038 SHALL cover flush and reset: flush with 1 closed and 1 partial entry plus a simultaneous write -> rok_o = 0, wok_o = 1, next write lands at word 0; rst_ni asserted mid-fill -> same result asynchronously.
